// File: rtl/csr_access_ctrl_if.sv
// CSR access bundle: request from execute, register-bank port, response to writeback.
// master = the execute/bank/writeback side, slave = csr_access_ctrl.
interface csr_access_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [4:0]            req_rs1_idx;
    logic [DATA_WIDTH-1:0] req_rs1_data;

    logic [ADDR_WIDTH-1:0] csr_addr;
    logic [DATA_WIDTH-1:0] csr_rdata;
    logic                  csr_addr_hit;
    logic                  csr_en;
    logic [1:0]            csr_op;
    logic [DATA_WIDTH-1:0] csr_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_illegal;

    modport master (
        output req_valid, req_funct3, req_addr, req_rs1_idx, req_rs1_data,
        input  req_ready,
        input  csr_addr, csr_en, csr_op, csr_wdata,
        output csr_rdata, csr_addr_hit,
        input  rsp_valid, rsp_rdata, rsp_illegal,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_funct3, req_addr, req_rs1_idx, req_rs1_data,
        output req_ready,
        output csr_addr, csr_en, csr_op, csr_wdata,
        input  csr_rdata, csr_addr_hit,
        output rsp_valid, rsp_rdata, rsp_illegal,
        input  rsp_ready
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// CSR access controller: accept one CSR instruction, read the CSR, issue at most
// one write strobe to the bank, then return the old value or an illegal flag.
module csr_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    csr_access_ctrl_if.slave   bus,
    output logic               busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] operand_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  illegal_q;
    logic                  accept;
    logic                  illegal_now;

    // Handshake and the illegal decision taken while in READ
    always_comb begin
        accept      = bus.req_valid & bus.req_ready;
        illegal_now = (op_q == 2'b00) | ~bus.csr_addr_hit |
                      (wr_q & (addr_q[ADDR_WIDTH-1 -: 2] == 2'b11));
    end

    // Access sequencing; flush overrides every transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= READ;
                READ:    if (flush) state <= IDLE;
                         else if (illegal_now || !wr_q) state <= RESP;
                         else state <= WRITE;
                WRITE:   state <= flush ? IDLE : RESP;
                RESP:    if (flush || bus.rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request latch at accept, old value and illegal flag captured in READ
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            addr_q    <= '0;
            operand_q <= '0;
            wr_q      <= 1'b0;
            rdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= bus.req_funct3[1:0];
                addr_q    <= bus.req_addr;
                operand_q <= bus.req_funct3[2] ?
                             {{(DATA_WIDTH-5){1'b0}}, bus.req_rs1_idx} : bus.req_rs1_data;
                wr_q      <= (bus.req_funct3[1:0] == 2'b01) | (bus.req_rs1_idx != 5'd0);
            end
            if (state == READ) begin
                rdata_q   <= bus.csr_rdata;
                illegal_q <= illegal_now;
            end
        end
    end

    // Outputs decoded from state so a reset cuts the strobe immediately
    always_comb begin
        bus.req_ready   = (state == IDLE) & ~flush & ~reset;
        bus.csr_addr    = addr_q;
        bus.csr_en      = (state == WRITE);
        bus.csr_op      = (state == WRITE) ? op_q : 2'b00;
        bus.csr_wdata   = (state == WRITE) ? operand_q : '0;
        bus.rsp_valid   = (state == RESP) & ~flush;
        bus.rsp_rdata   = rdata_q;
        bus.rsp_illegal = illegal_q;
        busy            = (state != IDLE);
    end
endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: transaction-level model of the
// expected strobe/response timing, checked every cycle, plus literal pins.
module tb_csr_access_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic busy;

    csr_access_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();

    csr_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model of the current access: strobe cycle, response window, busy window
    int          en_at   = -1;
    int          rv_lo   = 0;
    int          rv_hi   = 0;
    int          busy_lo = 0;
    int          busy_hi = 0;
    int          acc_cyc = 0;
    logic [1:0]  m_op    = 2'b00;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    logic        m_ill   = 1'b0;
    logic [11:0] m_addr  = '0;

    // What the DUT actually did, for literal pins
    int          seen_en    = -1;
    int          seen_rv    = -1;
    logic [1:0]  seen_op    = '0;
    logic [31:0] seen_wdata = '0;
    logic [31:0] seen_rdata = '0;
    logic        seen_ill   = 1'b0;

    logic e_en, e_rv, e_busy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!reset) begin
            e_en   = (cyc == en_at);
            e_rv   = (cyc >= rv_lo) && (cyc < rv_hi);
            e_busy = (cyc >= busy_lo) && (cyc < busy_hi);
            chk("csr_en", {31'b0, bus.csr_en}, {31'b0, e_en});
            chk("csr_op", {30'b0, bus.csr_op}, e_en ? {30'b0, m_op} : 32'd0);
            if (e_en) chk("csr_wdata", bus.csr_wdata, m_wdata);
            chk("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, e_rv});
            if (e_rv) begin
                chk("rsp_rdata", bus.rsp_rdata, m_rdata);
                chk("rsp_illegal", {31'b0, bus.rsp_illegal}, {31'b0, m_ill});
            end
            chk("busy", {31'b0, busy}, {31'b0, e_busy});
            chk("req_ready", {31'b0, bus.req_ready}, {31'b0, (!e_busy && !flush)});
            if (e_busy) chk("csr_addr", {20'b0, bus.csr_addr}, {20'b0, m_addr});
            if (bus.csr_en && seen_en < 0) begin
                seen_en = cyc; seen_op = bus.csr_op; seen_wdata = bus.csr_wdata;
            end
            if (bus.rsp_valid && seen_rv < 0) begin
                seen_rv = cyc; seen_rdata = bus.rsp_rdata; seen_ill = bus.rsp_illegal;
            end
        end
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_csr_en"},   {31'b0, bus.csr_en}, 32'd0);
        chk({tag, "_csr_op"},   {30'b0, bus.csr_op}, 32'd0);
        chk({tag, "_wdata"},    bus.csr_wdata, 32'd0);
        chk({tag, "_addr"},     {20'b0, bus.csr_addr}, 32'd0);
        chk({tag, "_rvalid"},   {31'b0, bus.rsp_valid}, 32'd0);
        chk({tag, "_rdata"},    bus.rsp_rdata, 32'd0);
        chk({tag, "_illegal"},  {31'b0, bus.rsp_illegal}, 32'd0);
        chk({tag, "_busy"},     {31'b0, busy}, 32'd0);
    endtask

    // fl: 0 none, 1 flush in READ, 2 flush in WRITE, 3 flush in RESP, 4 reset in WRITE
    task automatic do_req(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                          input logic [31:0] data, input logic [31:0] rd, input logic hit,
                          input int hold, input int fl);
        int c, lat, rv_lo0, fcyc;
        logic [31:0] operand;
        logic bad, wi, ill, wr;
        bus.csr_rdata    = rd;
        bus.csr_addr_hit = hit;
        bus.rsp_ready    = (hold == 0);
        bus.req_funct3   = f3;
        bus.req_addr     = addr;
        bus.req_rs1_idx  = idx;
        bus.req_rs1_data = data;
        bus.req_valid    = 1'b1;
        c = cyc;
        operand = f3[2] ? {27'b0, idx} : data;
        bad = (f3[1:0] == 2'b00);
        wi  = (f3[1:0] == 2'b01) || (idx != 5'd0);
        ill = bad || !hit || (wi && addr[11:10] == 2'b11);
        wr  = wi && !ill;
        m_op = f3[1:0]; m_wdata = operand; m_rdata = rd; m_ill = ill; m_addr = addr;
        acc_cyc = c; seen_en = -1; seen_rv = -1;
        lat = wr ? 3 : 2;
        busy_lo = c + 1;
        rv_lo0  = c + lat;
        rv_lo   = rv_lo0;
        rv_hi   = rv_lo0 + hold + 1;
        busy_hi = rv_hi;
        en_at   = wr ? c + 2 : -1;
        fcyc    = -1;
        case (fl)
            1: begin fcyc = c + 1; en_at = -1; rv_lo = 0; rv_hi = 0; busy_hi = c + 2; end
            2: begin fcyc = c + 2; rv_lo = 0; rv_hi = 0; busy_hi = c + 3; end
            3: begin fcyc = rv_lo0; rv_lo = 0; rv_hi = 0; busy_hi = rv_lo0 + 1; end
            default: ;
        endcase
        @(posedge clk); #1;
        bus.req_valid    = 1'b0;
        bus.req_funct3   = 3'b001;
        bus.req_addr     = 12'hFFF;
        bus.req_rs1_idx  = ~idx;
        bus.req_rs1_data = ~data;
        while (cyc < busy_hi) begin
            flush = (cyc == fcyc);
            bus.rsp_ready = (hold == 0) || (cyc >= rv_lo0 + hold);
            if (fl == 4 && cyc == c + 2) begin
                chk("pre_reset_csr_en", {31'b0, bus.csr_en}, 32'd1);
                #1 reset = 1'b1;
                #1;
                chk_reset_values("midreset");
                en_at = -1; rv_lo = 0; rv_hi = 0; busy_hi = cyc;
                @(posedge clk); #1 reset = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0;
        bus.req_rs1_idx = '0; bus.req_rs1_data = '0; bus.csr_rdata = '0;
        bus.csr_addr_hit = 1'b0; bus.rsp_ready = 1'b0;
        #2;
        chk_reset_values("reset");
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        busy_hi = cyc;
        #1;
        chk("ready_after_reset", {31'b0, bus.req_ready}, 32'd1);

        // CSRRW 0x300: write 2 cycles after accept, response after 3
        do_req(3'b001, 12'h300, 5'd1, 32'hDEADBEEF, 32'h00001800, 1'b1, 0, 0);
        chk("rw_en_lat", seen_en - acc_cyc, 32'd2);
        chk("rw_op", {30'b0, seen_op}, 32'd1);
        chk("rw_wdata", seen_wdata, 32'hDEADBEEF);
        chk("rw_rv_lat", seen_rv - acc_cyc, 32'd3);
        chk("rw_rdata", seen_rdata, 32'h00001800);
        chk("rw_illegal", {31'b0, seen_ill}, 32'd0);

        // CSRRS rs1=x0: read only
        do_req(3'b010, 12'h342, 5'd0, 32'hFFFFFFFF, 32'h8000000B, 1'b1, 0, 0);
        chk("rs0_no_write", seen_en, 32'hFFFFFFFF);
        chk("rs0_rv_lat", seen_rv - acc_cyc, 32'd2);
        chk("rs0_rdata", seen_rdata, 32'h8000000B);

        // CSRRCI zimm=5
        do_req(3'b111, 12'h300, 5'd5, 32'hFFFFFFFF, 32'h00001888, 1'b1, 0, 0);
        chk("rci_op", {30'b0, seen_op}, 32'd3);
        chk("rci_wdata", seen_wdata, 32'h00000005);

        // CSRRSI zimm=0: no write
        do_req(3'b110, 12'h300, 5'd0, 32'h12345678, 32'h00000088, 1'b1, 0, 0);
        chk("rsi0_no_write", seen_en, 32'hFFFFFFFF);

        // Illegal: write to read-only, unimplemented CSR, reserved funct3
        do_req(3'b001, 12'hC00, 5'd2, 32'h1, 32'h0000ABCD, 1'b1, 0, 0);
        chk("ro_illegal", {31'b0, seen_ill}, 32'd1);
        chk("ro_lat", seen_rv - acc_cyc, 32'd2);
        chk("ro_no_write", seen_en, 32'hFFFFFFFF);
        do_req(3'b010, 12'h7C5, 5'd3, 32'h4, 32'h0, 1'b0, 0, 0);
        chk("miss_illegal", {31'b0, seen_ill}, 32'd1);
        do_req(3'b100, 12'h300, 5'd1, 32'h4, 32'h00001800, 1'b1, 0, 0);
        chk("f3_100_illegal", {31'b0, seen_ill}, 32'd1);
        chk("f3_100_no_write", seen_en, 32'hFFFFFFFF);

        // Read-only CSR read with x0 is legal; set with nonzero source is not
        do_req(3'b010, 12'hC00, 5'd0, 32'h0, 32'h00C0FFEE, 1'b1, 0, 0);
        chk("ro_read_legal", {31'b0, seen_ill}, 32'd0);
        do_req(3'b110, 12'hC01, 5'd3, 32'h0, 32'h11111111, 1'b1, 0, 0);
        chk("ro_rsi_illegal", {31'b0, seen_ill}, 32'd1);

        // Writeback stall for 5 cycles, then a back-to-back request
        do_req(3'b010, 12'h304, 5'd7, 32'h000000F0, 32'h00000A0A, 1'b1, 5, 0);
        chk("stall_rv_lat", seen_rv - acc_cyc, 32'd3);
        chk("stall_wdata", seen_wdata, 32'h000000F0);
        do_req(3'b011, 12'h341, 5'd2, 32'h0000000C, 32'h00000100, 1'b1, 0, 0);
        chk("b2b_op", {30'b0, seen_op}, 32'd3);

        // Flush in READ, WRITE, RESP
        do_req(3'b001, 12'h300, 5'd1, 32'h5A5A5A5A, 32'h1, 1'b1, 0, 1);
        chk("flush_read_no_write", seen_en, 32'hFFFFFFFF);
        chk("flush_read_no_rsp", seen_rv, 32'hFFFFFFFF);
        do_req(3'b001, 12'h300, 5'd1, 32'hA5A5A5A5, 32'h2, 1'b1, 0, 2);
        chk("flush_write_strobe", seen_en - acc_cyc, 32'd2);
        chk("flush_write_no_rsp", seen_rv, 32'hFFFFFFFF);
        do_req(3'b010, 12'h342, 5'd0, 32'h0, 32'h3, 1'b1, 0, 3);
        chk("flush_resp_no_rsp", seen_rv, 32'hFFFFFFFF);

        // Flush while idle blocks acceptance
        bus.req_funct3 = 3'b001; bus.req_addr = 12'h300; bus.req_valid = 1'b1; flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("flush_idle_ready", {31'b0, bus.req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        flush = 1'b0; bus.req_valid = 1'b0;
        @(posedge clk); #1;

        // Reset during WRITE
        do_req(3'b001, 12'h305, 5'd4, 32'hCAFEF00D, 32'h77777777, 1'b1, 0, 4);
        @(posedge clk); #1;
        do_req(3'b010, 12'h300, 5'd0, 32'h0, 32'h00001800, 1'b1, 0, 0);
        chk("post_reset_rdata", seen_rdata, 32'h00001800);

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
